// File: rtl/conv_pe_sequencer.sv
// Walks one binary-activation PE through every tap of a kernel window and
// hands the finished partial sum downstream over a valid/ready handshake.
module conv_pe_sequencer #(
    parameter int DATA_WIDTH      = 8,
    parameter int PSUM_DATA_WIDTH = 12,
    parameter int BIAS_DATA_WIDTH = 32,
    parameter int KERNEL_TAPS     = 9,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic signed [BIAS_DATA_WIDTH-1:0] bias_in,
    output logic                              busy,
    output logic                              tap_rd_en,
    output logic        [ADDR_WIDTH-1:0]      tap_addr,
    input  logic signed [DATA_WIDTH-1:0]      weight_rd,
    input  logic                              infmap_rd,
    output logic signed [PSUM_DATA_WIDTH-1:0] pe_inpsum,
    output logic signed [DATA_WIDTH-1:0]      pe_weight,
    output logic signed [BIAS_DATA_WIDTH-1:0] pe_bias,
    output logic                              pe_infmap_value,
    input  logic signed [PSUM_DATA_WIDTH-1:0] pe_outpsum,
    output logic signed [PSUM_DATA_WIDTH-1:0] result,
    output logic                              result_valid,
    input  logic                              result_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERNEL_TAPS - 1);

    logic [1:0]                        state_reg, state_next;
    logic signed [PSUM_DATA_WIDTH-1:0] acc_reg, acc_next;
    logic signed [PSUM_DATA_WIDTH-1:0] result_reg, result_next;
    logic signed [BIAS_DATA_WIDTH-1:0] bias_reg, bias_next;
    logic [ADDR_WIDTH-1:0]             addr_reg, addr_next;
    logic                              rd_en_reg, rd_en_next;
    logic                              rd_valid_reg, rd_valid_next;
    logic                              first_reg, first_next;

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        result_next   = result_reg;
        bias_next     = bias_reg;
        addr_next     = addr_reg;
        rd_en_next    = rd_en_reg;
        rd_valid_next = rd_en_reg;
        first_next    = first_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bias_next  = bias_in;
                    acc_next   = '0;
                    addr_next  = '0;
                    rd_en_next = 1'b1;
                    first_next = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rd_en_reg) begin
                    if (addr_reg == LAST_ADDR) begin
                        rd_en_next = 1'b0;
                        addr_next  = '0;
                    end else begin
                        addr_next = addr_reg + 1'b1;
                    end
                end
                // Reads issue back to back, so a return with no read still
                // outstanding behind it is the last tap of the window.
                if (rd_valid_reg) begin
                    acc_next   = pe_outpsum;
                    first_next = 1'b0;
                    if (!rd_en_reg) begin
                        result_next = pe_outpsum;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            result_reg   <= '0;
            bias_reg     <= '0;
            addr_reg     <= '0;
            rd_en_reg    <= 1'b0;
            rd_valid_reg <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            result_reg   <= result_next;
            bias_reg     <= bias_next;
            addr_reg     <= addr_next;
            rd_en_reg    <= rd_en_next;
            rd_valid_reg <= rd_valid_next;
            first_reg    <= first_next;
        end
    end

    assign busy            = (state_reg != IDLE);
    assign tap_rd_en       = rd_en_reg;
    assign tap_addr        = addr_reg;
    assign pe_inpsum       = acc_reg;
    assign pe_weight       = rd_valid_reg ? weight_rd : '0;
    assign pe_infmap_value = rd_valid_reg & infmap_rd;
    assign pe_bias         = (rd_valid_reg && first_reg) ? bias_reg : '0;
    assign result          = result_reg;
    assign result_valid    = (state_reg == DONE);

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed bench for conv_pe_sequencer: a 9-tap and a 1-tap instance, each with
// a registered tap buffer model and a behavioural binary-activation PE.
`timescale 1ns/1ps
module tb_conv_pe_sequencer;

    localparam int DW = 8;
    localparam int PW = 12;
    localparam int BW = 32;
    localparam int K  = 9;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic                 reset;
    logic                 start, start_k1;
    logic signed [BW-1:0] bias_in, bias_in_k1;
    logic                 busy, busy_k1;
    logic                 tap_rd_en, tap_rd_en_k1;
    logic [AW-1:0]        tap_addr;
    logic [0:0]           tap_addr_k1;
    logic signed [DW-1:0] weight_rd, weight_rd_k1;
    logic                 infmap_rd, infmap_rd_k1;
    logic signed [PW-1:0] pe_inpsum, pe_inpsum_k1;
    logic signed [DW-1:0] pe_weight, pe_weight_k1;
    logic signed [BW-1:0] pe_bias, pe_bias_k1;
    logic                 pe_infmap_value, pe_infmap_value_k1;
    logic signed [PW-1:0] pe_outpsum, pe_outpsum_k1;
    logic signed [PW-1:0] result, result_k1;
    logic                 result_valid, result_valid_k1;
    logic                 result_ready, result_ready_k1;

    logic [DW-1:0] w_mem [16];
    logic          f_mem [16];
    logic [DW-1:0] w_mem_k1 [2];
    logic          f_mem_k1 [2];

    conv_pe_sequencer #(.DATA_WIDTH(DW), .PSUM_DATA_WIDTH(PW), .BIAS_DATA_WIDTH(BW),
                        .KERNEL_TAPS(K), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .bias_in(bias_in), .busy(busy),
        .tap_rd_en(tap_rd_en), .tap_addr(tap_addr), .weight_rd(weight_rd),
        .infmap_rd(infmap_rd), .pe_inpsum(pe_inpsum), .pe_weight(pe_weight),
        .pe_bias(pe_bias), .pe_infmap_value(pe_infmap_value), .pe_outpsum(pe_outpsum),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    conv_pe_sequencer #(.DATA_WIDTH(DW), .PSUM_DATA_WIDTH(PW), .BIAS_DATA_WIDTH(BW),
                        .KERNEL_TAPS(1), .ADDR_WIDTH(1)) u_dut_k1 (
        .clk(clk), .reset(reset), .start(start_k1), .bias_in(bias_in_k1), .busy(busy_k1),
        .tap_rd_en(tap_rd_en_k1), .tap_addr(tap_addr_k1), .weight_rd(weight_rd_k1),
        .infmap_rd(infmap_rd_k1), .pe_inpsum(pe_inpsum_k1), .pe_weight(pe_weight_k1),
        .pe_bias(pe_bias_k1), .pe_infmap_value(pe_infmap_value_k1),
        .pe_outpsum(pe_outpsum_k1), .result(result_k1), .result_valid(result_valid_k1),
        .result_ready(result_ready_k1)
    );

    // Tap buffers: one-cycle registered read
    always @(posedge clk) begin
        if (tap_rd_en) begin
            weight_rd <= w_mem[tap_addr];
            infmap_rd <= f_mem[tap_addr];
        end
        if (tap_rd_en_k1) begin
            weight_rd_k1 <= w_mem_k1[tap_addr_k1];
            infmap_rd_k1 <= f_mem_k1[tap_addr_k1];
        end
    end

    // PE: inpsum + (+/-weight + bias), truncated to the psum width
    int pe_sum, pe_sum_k1;
    always_comb begin
        pe_sum    = pe_inpsum + (pe_infmap_value ? pe_weight : -pe_weight) + pe_bias;
        pe_sum_k1 = pe_inpsum_k1 + (pe_infmap_value_k1 ? pe_weight_k1 : -pe_weight_k1) + pe_bias_k1;
    end
    assign pe_outpsum    = pe_sum[PW-1:0];
    assign pe_outpsum_k1 = pe_sum_k1[PW-1:0];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [DW-1:0] w, input logic f);
        for (int i = 0; i < 16; i++) begin
            w_mem[i] = w;
            f_mem[i] = f;
        end
    endtask

    task automatic pulse_start(input int b);
        start   = 1'b1;
        bias_in = b;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (!result_valid && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; start_k1 = 1'b0;
        bias_in = 0; bias_in_k1 = 0;
        result_ready = 1'b1; result_ready_k1 = 1'b1;
        fill_const(8'd0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        vectors++;
        if (tap_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %0b expected 0", tap_rd_en); end
        vectors++;
        if (tap_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", tap_addr); end
        vectors++;
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", result_valid); end
        vectors++;
        if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result); end
        vectors++;
        if (pe_inpsum !== '0 || pe_bias !== '0) begin
            miscompares++; $display("FAIL reset_pe: inpsum %0d bias %0d expected 0 0", pe_inpsum, pe_bias);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        fill_const(8'd1, 1'b1);
        result_ready = 1'b1;
        pulse_start(0);
        for (int k = 0; k < K; k++) begin
            vectors++;
            if (tap_rd_en !== 1'b1 || tap_addr !== AW'(k) || result_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_issue%0d: rd_en %0b addr %0d valid %0b expected 1 %0d 0",
                         k, tap_rd_en, tap_addr, result_valid, k);
            end
            tick();
        end
        vectors++;
        if (tap_rd_en !== 1'b0 || tap_addr !== '0 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_tail: rd_en %0b addr %0d valid %0b expected 0 0 0",
                     tap_rd_en, tap_addr, result_valid);
        end
        tick();
        vectors++;
        if (result_valid !== 1'b1 || result !== 12'd9) begin
            miscompares++;
            $display("FAIL basic_result: valid %0b result %0d expected 1 9", result_valid, result);
        end
        tick();
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 12'd9) begin
            miscompares++;
            $display("FAIL basic_release: valid %0b busy %0b result %0d expected 0 0 9",
                     result_valid, busy, result);
        end
        $display("basic window: result %0d", result);
    endtask

    task automatic test_bias_once();
        int n;
        fill_const(8'd2, 1'b0);
        pulse_start(5);
        wait_valid(20, n);
        vectors++;
        if (n !== K + 1 || result !== 12'hFF3) begin
            miscompares++;
            $display("FAIL bias_once: cycles %0d result %h expected %0d ff3", n, result, K + 1);
        end
        $display("bias-once window: result %h", result);
        tick();
    endtask

    task automatic test_wrap();
        int n;
        fill_const(8'd127, 1'b1);
        pulse_start(1000);
        wait_valid(20, n);
        vectors++;
        if (n !== K + 1 || result !== 12'h85F) begin
            miscompares++;
            $display("FAIL wrap: cycles %0d result %h expected %0d 85f", n, result, K + 1);
        end
        $display("wrap window: result %h", result);
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        fill_const(8'd3, 1'b1);
        result_ready = 1'b0;
        pulse_start(-7);
        wait_valid(20, n);
        vectors++;
        if (n !== K + 1 || result !== 12'd20) begin
            miscompares++;
            $display("FAIL bp_first: cycles %0d result %0d expected %0d 20", n, result, K + 1);
        end
        fill_const(8'd5, 1'b1);
        start = 1'b1;
        bias_in = 100;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (result_valid !== 1'b1 || result !== 12'd20 || busy !== 1'b1 || tap_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: valid %0b result %0d busy %0b rd_en %0b expected 1 20 1 0",
                         c, result_valid, result, busy, tap_rd_en);
            end
        end
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || tap_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: valid %0b busy %0b rd_en %0b expected 0 0 0",
                     result_valid, busy, tap_rd_en);
        end
        pulse_start(0);
        wait_valid(20, n);
        vectors++;
        if (n !== K + 1 || result !== 12'd45) begin
            miscompares++;
            $display("FAIL bp_fresh: cycles %0d result %0d expected %0d 45", n, result, K + 1);
        end
        $display("backpressure: fresh window result %0d", result);
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        fill_const(8'd1, 1'b1);
        pulse_start(50);
        repeat (4) tick();
        vectors++;
        if (tap_addr !== 4'd4) begin
            miscompares++; $display("FAIL mid_addr: got %0d expected 4", tap_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || tap_rd_en !== 1'b0 || tap_addr !== '0 || result_valid !== 1'b0 ||
            result !== '0 || pe_inpsum !== '0 || pe_weight !== '0 || pe_bias !== '0 ||
            pe_infmap_value !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: busy %0b rd_en %0b addr %0d valid %0b result %0d inpsum %0d weight %0d bias %0d fm %0b expected all 0",
                     busy, tap_rd_en, tap_addr, result_valid, result, pe_inpsum, pe_weight,
                     pe_bias, pe_infmap_value);
        end
        for (int i = 0; i < K; i++) begin
            w_mem[i] = DW'(i + 1);
            f_mem[i] = (i % 2 == 0);
        end
        pulse_start(0);
        wait_valid(20, n);
        vectors++;
        if (n !== K + 1 || result !== 12'd5) begin
            miscompares++;
            $display("FAIL mid_fresh: cycles %0d result %0d expected %0d 5", n, result, K + 1);
        end
        $display("reset-mid-run: fresh window result %0d", result);
        tick();
    endtask

    task automatic test_single_tap();
        int n;
        w_mem_k1[0] = 8'hFD;
        f_mem_k1[0] = 1'b0;
        w_mem_k1[1] = 8'h00;
        f_mem_k1[1] = 1'b0;
        result_ready_k1 = 1'b1;
        start_k1   = 1'b1;
        bias_in_k1 = -2;
        tick();
        start_k1 = 1'b0;
        vectors++;
        if (tap_rd_en_k1 !== 1'b1 || tap_addr_k1 !== 1'b0) begin
            miscompares++;
            $display("FAIL k1_issue: rd_en %0b addr %0d expected 1 0", tap_rd_en_k1, tap_addr_k1);
        end
        n = 0;
        while (!result_valid_k1 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 2 || result_k1 !== 12'd1) begin
            miscompares++;
            $display("FAIL k1_result: cycles %0d result %0d expected 2 1", n, result_k1);
        end
        $display("single-tap window: result %0d", result_k1);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias_once();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_single_tap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
